alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: ALU_Exec

Interface
REQ-001 SHALL have ports: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst_i  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start_i  input  1  request to execute one operation; accepted only when ready_o=1.
REQ-004 SHALL have ports: ALUCtrl_i  input  3  operation code, sampled at accept.
REQ-005 SHALL have ports: data1_i  input  32  operand A, sampled at accept.
REQ-006 SHALL have ports: data2_i  input  32  operand B or shift amount, sampled at accept.
REQ-007 SHALL have ports: flush_i  input  1  abort any in-flight operation.
REQ-008 SHALL have ports: ready_o  output  1  high only in IDLE.
REQ-009 SHALL have ports: valid_o  output  1  one-cycle result strobe.
REQ-010 SHALL have ports: data_o  output  32  result, held until overwritten by the next completed op.
REQ-011 SHALL have ports: zero_o  output  1  (data_o == 0), updated together with data_o.
REQ-012 SHALL have ports: busy_o  output  1  high in MUL state.

Function
REQ-013 SHALL decode ALUCtrl_i: 000 SLL (A << B[4:0]), 001 ADD, 010 SUB (A-B), 011 AND, 100 OR, 110 MUL, 111 SRA (A >>> B[4:0], sign-filled), 101 treated as ADD.
REQ-014 SHALL use 32-bit wrap-around arithmetic; no overflow/carry output; MUL returns low 32 bits of product.
REQ-015 SHALL implement states IDLE, MUL, DONE; reset state IDLE.
REQ-016 Accept = rising edge with state IDLE, start_i=1, flush_i=0; operands and code are latched at that edge.
REQ-017 Non-MUL accept SHALL compute the result at the accept edge, load data_o/zero_o, go to DONE; valid_o=1 in the following cycle (latency 1).
REQ-018 MUL accept SHALL load multiplicand=A, multiplier=B, accumulator=0, counter=0, go to MUL.
REQ-019 Each MUL edge SHALL add the multiplicand to the accumulator if multiplier[0]=1, shift the multiplicand left 1, shift the multiplier right 1, and increment the 5-bit counter.
REQ-020 On the MUL edge with counter=31, SHALL load data_o with the final accumulator and go to DONE; valid_o=1 exactly 33 cycles after the accept edge.
REQ-021 DONE SHALL last one cycle with valid_o=1, ready_o=0, then return to IDLE; minimum issue interval is 2 cycles (non-MUL) and 34 cycles (MUL).
REQ-022 start_i while ready_o=0 SHALL be ignored: not queued, no state change.
REQ-023 flush_i=1 in MUL or DONE SHALL return to IDLE at that edge, suppress valid_o, and leave data_o/zero_o unchanged.
REQ-024 flush_i=1 coincident with start_i in IDLE SHALL win; the request is not accepted.
REQ-025 ready_o, valid_o and busy_o SHALL be derived from the state register only: no combinational path from inputs.

Reset
REQ-026 rst_i=1 at an edge SHALL force IDLE, data_o=0, zero_o=1, valid_o=0, busy_o=0, ready_o=1, and counter/accumulator=0; rst_i has priority over flush_i and start_i.
REQ-027 Reset during MUL SHALL abort the op with no valid_o pulse afterwards.

Verification
REQ-028 SUB A=5, B=5 -> one cycle later valid_o=1, data_o=0x00000000, zero_o=1; ADD A=0xFFFFFFFF, B=1 -> data_o=0, zero_o=1.
REQ-029 MUL A=7, B=6 -> busy_o high 32 cycles; valid_o at accept+33, data_o=42; MUL A=0xFFFFFFFF, B=2 -> 0xFFFFFFFE.
REQ-030 SRA A=0x80000000, B=4 -> 0xF8000000; SLL A=1, B=0x25 -> 0x00000020 (only B[4:0] used); code 101 with A=3, B=4 -> 7.
REQ-031 start_i with ADD issued at cycles 5..20 of a MUL -> ignored; only the MUL result appears, single valid_o pulse.
REQ-032 flush_i at MUL cycle 10 -> IDLE next cycle, no valid_o, data_o retains previous result; rst_i at MUL cycle 10 -> data_o=0, zero_o=1, ready_o=1.
REQ-033 Back-to-back: AND 0xF0F0 & 0x0FF0 then OR 0xF000 | 0x000F issued at first ready -> valid_o pulses 2 cycles apart, results 0x00F0 then 0xF00F.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: single-issue execute unit with one-cycle ALU operations and a
// 32-cycle shift-and-add multiplier.
//
// Ports:
//   clk_i      - clock, all state updates on the rising edge
//   rst_i      - synchronous active-high reset
//   start_i    - request one operation; accepted only while ready_o=1
//   ALUCtrl_i  - operation code (000 SLL, 001/101 ADD, 010 SUB, 011 AND,
//                100 OR, 110 MUL, 111 SRA), sampled at accept
//   data1_i    - operand A, sampled at accept
//   data2_i    - operand B / shift amount, sampled at accept
//   flush_i    - abort any in-flight operation; beats start_i in IDLE
//   ready_o    - high in IDLE
//   valid_o    - one-cycle result strobe (DONE state)
//   data_o     - result, held until the next completed operation
//   zero_o     - data_o == 0, updated together with data_o
//   busy_o     - high while the multiplier is iterating
module alu_exec (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  ALUCtrl_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic        flush_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic        zero_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL = 3'b110;

    state_t      state_q;
    logic [31:0] data_q;
    logic        zero_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] acc_q;
    logic [4:0]  cnt_q;

    logic [31:0] alu_res;
    logic [31:0] acc_d;

    // Single-cycle operations, evaluated on the live inputs so the result
    // can be captured at the accept edge.
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            3'b000:         alu_res = data1_i << data2_i[4:0];
            3'b001, 3'b101: alu_res = data1_i + data2_i;
            3'b010:         alu_res = data1_i - data2_i;
            3'b011:         alu_res = data1_i & data2_i;
            3'b100:         alu_res = data1_i | data2_i;
            3'b111:         alu_res = $signed(data1_i) >>> data2_i[4:0];
            default:        alu_res = '0;  // MUL takes the iterative path
        endcase
    end

    // One shift-and-add step; also the final product on the last step.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            zero_q   <= 1'b1;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        if (ALUCtrl_i == OP_MUL) begin
                            mcand_q  <= data1_i;
                            mplier_q <= data2_i;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= S_MUL;
                        end else begin
                            data_q  <= alu_res;
                            zero_q  <= (alu_res == '0);
                            state_q <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            data_q  <= acc_d;
                            zero_q  <= (acc_d == '0);
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode the state register only.
    assign ready_o = (state_q == S_IDLE);
    assign valid_o = (state_q == S_DONE);
    assign busy_o  = (state_q == S_MUL);
    assign data_o  = data_q;
    assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: table-driven and randomized checks of alu_exec against a
// plain-arithmetic reference, plus hand sequences for start-while-busy,
// flush and reset during a multiply.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        flush;
    logic        ready;
    logic        valid;
    logic [31:0] data;
    logic        zero;
    logic        busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned valid_seen = 0;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .ALUCtrl_i (ctrl),
        .data1_i   (d1),
        .data2_i   (d2),
        .flush_i   (flush),
        .ready_o   (ready),
        .valid_o   (valid),
        .data_o    (data),
        .zero_o    (zero),
        .busy_o    (busy)
    );

    // Count every cycle in which the result strobe is high.
    always @(negedge clk) begin
        if (valid) valid_seen++;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference result straight from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] prod;
        int unsigned sh;
        sh = b % 32;
        case (op)
            3'd0:       return a << sh;
            3'd1, 3'd5: return a + b;
            3'd2:       return a - b;
            3'd3:       return a & b;
            3'd4:       return a | b;
            3'd6: begin
                prod = 64'(a) * 64'(b);
                return prod[31:0];
            end
            default:    return $unsigned($signed(a) >>> sh);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE and check latency, result, flags and return to IDLE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        int k;
        int busy_n;
        int wait_n;
        int lat;
        wait_n = 0;
        while (!ready && wait_n < 50) begin
            tick();
            wait_n++;
        end
        check({nm, " ready_before"}, 32'(ready), 32'd1);
        @(negedge clk);
        start = 1'b1; ctrl = op; d1 = a; d2 = b;
        tick();
        start = 1'b0;
        lat = (op == 3'b110) ? 33 : 1;
        k = 1;
        busy_n = 0;
        while (!valid && k < 40) begin
            if (busy) busy_n++;
            tick();
            k++;
        end
        check({nm, " latency"}, 32'(k), 32'(lat));
        check({nm, " data"}, data, exp);
        check({nm, " zero"}, 32'(zero), 32'(exp == 32'd0));
        check({nm, " ready_in_done"}, 32'(ready), 32'd0);
        check({nm, " busy_in_done"}, 32'(busy), 32'd0);
        if (op == 3'b110) check({nm, " busy_cycles"}, 32'(busy_n), 32'd32);
        tick();
        check({nm, " valid_after"}, 32'(valid), 32'd0);
        check({nm, " ready_after"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int k;
        int vs0;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vt[0]  = '{3'b010, 32'd5,          32'd5,          32'h0000_0000, "SUB_5_5"};
        vt[1]  = '{3'b001, 32'hFFFF_FFFF,  32'd1,          32'h0000_0000, "ADD_wrap"};
        vt[2]  = '{3'b110, 32'd7,          32'd6,          32'd42,        "MUL_7_6"};
        vt[3]  = '{3'b110, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE, "MUL_m1_2"};
        vt[4]  = '{3'b111, 32'h8000_0000,  32'd4,          32'hF800_0000, "SRA_neg"};
        vt[5]  = '{3'b000, 32'd1,          32'h25,         32'h0000_0020, "SLL_b_masked"};
        vt[6]  = '{3'b101, 32'd3,          32'd4,          32'd7,         "OP101_add"};
        vt[7]  = '{3'b011, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0, "AND_b2b"};
        vt[8]  = '{3'b100, 32'h0000_F000,  32'h0000_000F,  32'h0000_F00F, "OR_b2b"};
        vt[9]  = '{3'b111, 32'h7FFF_FFFF,  32'd31,         32'h0000_0000, "SRA_pos31"};
        vt[10] = '{3'b000, 32'd1,          32'd31,         32'h8000_0000, "SLL_31"};
        vt[11] = '{3'b010, 32'd0,          32'd1,          32'hFFFF_FFFF, "SUB_under"};
        vt[12] = '{3'b110, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000, "MUL_trunc"};
        vt[13] = '{3'b110, 32'h8000_0001,  32'hFFFF_FFFF,  32'h7FFF_FFFF, "MUL_big"};

        rst = 1'b1; start = 1'b0; ctrl = '0; d1 = '0; d2 = '0; flush = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_data",  data,       32'd0);
        check("rst_zero",  32'(zero),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Consecutive entries run back to back (AND then OR issue 2 cycles apart).
        for (int i = 0; i < 14; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].name);
        end

        // start_i with ADD held during MUL cycles 5..20 must be ignored.
        vs0 = valid_seen;
        @(negedge clk);
        start = 1'b1; ctrl = 3'b110; d1 = 32'd7; d2 = 32'd6;
        tick();
        start = 1'b0;
        k = 1;
        while (!valid && k < 40) begin
            @(negedge clk);
            if (k >= 4 && k < 20) begin
                start = 1'b1; ctrl = 3'b001; d1 = 32'd1; d2 = 32'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0;
        check("busy_start latency", 32'(k), 32'd33);
        check("busy_start data", data, 32'd42);
        tick();
        tick();
        tick();
        check("busy_start pulses", 32'(valid_seen - vs0), 32'd1);
        check("busy_start idle", 32'(ready), 32'd1);

        // Flush at MUL cycle 10: back to IDLE, no strobe, result retained.
        run_op(3'b001, 32'h10, 32'h20, 32'h30, "ADD_pre_flush");
        @(negedge clk);
        start = 1'b1; ctrl = 3'b110; d1 = 32'd9; d2 = 32'd9;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("flush pre_busy", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vs0 = valid_seen;
        check("flush ready", 32'(ready), 32'd1);
        check("flush valid", 32'(valid), 32'd0);
        check("flush busy",  32'(busy),  32'd0);
        check("flush data",  data,       32'h30);
        check("flush zero",  32'(zero),  32'd0);
        repeat (40) tick();
        check("flush no_pulse", 32'(valid_seen - vs0), 32'd0);
        check("flush data_later", data, 32'h30);

        // Reset at MUL cycle 10: abort and clear the result.
        @(negedge clk);
        start = 1'b1; ctrl = 3'b110; d1 = 32'd3; d2 = 32'd5;
        tick();
        start = 1'b0;
        repeat (9) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vs0 = valid_seen;
        check("mulrst ready", 32'(ready), 32'd1);
        check("mulrst busy",  32'(busy),  32'd0);
        check("mulrst data",  data,       32'd0);
        check("mulrst zero",  32'(zero),  32'd1);
        repeat (40) tick();
        check("mulrst no_pulse", 32'(valid_seen - vs0), 32'd0);

        // Flush coincident with start in IDLE wins.
        run_op(3'b001, 32'd1, 32'd1, 32'd2, "ADD_pre_idleflush");
        vs0 = valid_seen;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; ctrl = 3'b001; d1 = 32'd5; d2 = 32'd5;
        tick();
        start = 1'b0; flush = 1'b0;
        check("idleflush ready", 32'(ready), 32'd1);
        check("idleflush valid", 32'(valid), 32'd0);
        check("idleflush data",  data,       32'd2);
        tick();
        check("idleflush no_pulse", 32'(valid_seen - vs0), 32'd0);

        // Reset beats start.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; ctrl = 3'b001; d1 = 32'd5; d2 = 32'd5;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rststart ready", 32'(ready), 32'd1);
        check("rststart data",  data,       32'd0);
        check("rststart zero",  32'(zero),  32'd1);
        tick();
        check("rststart valid", 32'(valid), 32'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (i % 9 == 0) ra = '0;
            run_op(rop, ra, rb, ref_alu(rop, ra, rb), $sformatf("rand%0d_op%0d", i, rop));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
